// File: rtl/dlfp_pkg.sv
// Shared widths, flag bit positions and response record for the DLFloat16
// multiplier scheduler.
package dlfp_pkg;

  localparam int unsigned DLF16_W    = 16;
  localparam int unsigned DLF_RES_W  = 20;
  localparam int unsigned DLF_FLAG_W = 5;
  // Wide enough for the largest supported requester count (8)
  localparam int unsigned DLF_ID_W   = 3;

  localparam int unsigned FLG_INVALID   = 4;
  localparam int unsigned FLG_INEXACT   = 3;
  localparam int unsigned FLG_OVERFLOW  = 2;
  localparam int unsigned FLG_UNDERFLOW = 1;
  localparam int unsigned FLG_DIVZERO   = 0;

  typedef struct packed {
    logic [DLF_ID_W-1:0]   id;
    logic [DLF_RES_W-1:0]  result;
    logic [DLF_FLAG_W-1:0] flags;
  } dlf_rsp_t;

endpackage

// File: rtl/dlfp_rr_arb.sv
// Rotating-priority arbiter: grants the first set request at or above ptr,
// wrapping around, when enable is high.
module dlfp_rr_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] sel;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sel       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sel = IDW'((32'(ptr) + k) % NUM_REQ);
      if (enable && !found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/dlfp_mul_sched.sv
// Round-robin scheduler sharing one registered DLFloat16 multiplier among
// NUM_REQ requesters, with in-order, credit-protected result return.
module dlfp_mul_sched
  import dlfp_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MUL_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [DLF16_W*NUM_REQ-1:0]     req_a,
  input  logic [DLF16_W*NUM_REQ-1:0]     req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DLF16_W-1:0]             mul_a,
  output logic [DLF16_W-1:0]             mul_b,
  input  logic [DLF_RES_W-1:0]           mul_c,
  input  logic [DLF_FLAG_W-1:0]          mul_flags,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [DLF_RES_W-1:0]           rsp_result,
  output logic [DLF_FLAG_W-1:0]          rsp_flags
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic               credit_ok;
  logic               accept;
  logic               push;
  logic               pop;

  logic [DLF16_W-1:0] op_a [NUM_REQ];
  logic [DLF16_W-1:0] op_b [NUM_REQ];

  logic [MUL_LAT:0]   tok_v;
  logic [IDW-1:0]     tok_id [MUL_LAT+1];

  dlf_rsp_t           mem [FIFO_DEPTH];
  dlf_rsp_t           head;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      op_a[i] = req_a[i*DLF16_W +: DLF16_W];
      op_b[i] = req_b[i*DLF16_W +: DLF16_W];
    end
  end

  // Every in-flight token already owns a FIFO slot, so the exit write never stalls
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);

  dlfp_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (credit_ok),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign push      = tok_v[MUL_LAT];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign head      = mem[rd_ptr];

  assign rsp_id     = rsp_valid ? IDW'(head.id) : '0;
  assign rsp_result = rsp_valid ? head.result   : '0;
  assign rsp_flags  = rsp_valid ? head.flags    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      tok_v      <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      for (int unsigned s = 0; s <= MUL_LAT; s++) tok_id[s] <= '0;
    end else begin
      if (accept) begin
        mul_a  <= op_a[grant_idx];
        mul_b  <= op_b[grant_idx];
        rr_ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
      end else begin
        mul_a <= '0;
        mul_b <= '0;
      end
      tok_v[0]  <= accept;
      tok_id[0] <= grant_idx;
      for (int unsigned s = 1; s <= MUL_LAT; s++) begin
        tok_v[s]  <= tok_v[s-1];
        tok_id[s] <= tok_id[s-1];
      end
      inflight   <= inflight + CW'(accept) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset: outputs are gated by rsp_valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{id: DLF_ID_W'(tok_id[MUL_LAT]), result: mul_c, flags: mul_flags};
    end
  end

endmodule

// File: tb/tb_dlfp_mul_sched.sv
// Bench for dlfp_mul_sched: attached multiplier model plus a queue-based
// reference of grants, credits and in-order responses.
module tb_dlfp_mul_sched;

  localparam int unsigned NR    = 4;
  localparam int unsigned LAT   = 1;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [16*NR-1:0] req_a, req_b;
  logic [NR-1:0] req_ready;
  logic [15:0]   mul_a, mul_b;
  logic [19:0]   mul_c;
  logic [4:0]    mul_flags;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id;
  logic [19:0]   rsp_result;
  logic [4:0]    rsp_flags;

  dlfp_mul_sched #(.NUM_REQ(NR), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .mul_flags(mul_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  // Simplified DLFloat16 product: {result[19:0], flags[4:0]}
  function automatic logic [24:0] dlf_mul(input logic [15:0] a, input logic [15:0] b);
    int          e;
    logic [19:0] p;
    logic [12:0] m;
    logic        lost, s;
    s = a[15] ^ b[15];
    p = {1'b1, a[8:0]} * {1'b1, b[8:0]};
    e = int'(a[14:9]) + int'(b[14:9]) - 31;
    if (p[19]) begin e++; m = p[18:6]; lost = |p[5:0]; end
    else       begin      m = p[17:5]; lost = |p[4:0]; end
    if (e > 62) return {s, 6'h3F, 13'h0, 5'b00100};
    if (e < 1)  return {s, 19'h0, 5'b00010};
    return {s, e[5:0], m, (lost ? 5'b01000 : 5'b00000)};
  endfunction

  // Registered multiplier with LAT=1
  always @(posedge clk) {mul_c, mul_flags} <= dlf_mul(mul_a, mul_b);

  typedef struct {
    int unsigned id;
    logic [15:0] a, b;
    int unsigned due;
  } item_t;

  item_t       pend[$];
  item_t       fifo[$];
  int unsigned m_ptr, edge_n;
  logic [15:0] exp_a, exp_b;
  int unsigned n_tests, n_fail;
  logic [3:0]  obs_ready;
  logic        obs_valid;
  logic [1:0]  obs_id;
  logic [19:0] obs_res;
  logic [4:0]  obs_flags;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  // One clock: check at negedge against the model, then advance the model at posedge
  task automatic step();
    bit          found;
    int unsigned gi, idx;
    logic [3:0]  exp_rdy;
    logic [24:0] r;
    logic        exp_pop;
    @(negedge clk);
    found = 0; gi = 0; exp_rdy = '0;
    if (pend.size() + fifo.size() < DEPTH)
      for (int unsigned k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (!found && req_valid[idx]) begin found = 1; gi = idx; end
      end
    if (found) exp_rdy[gi] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("mul_a", 32'(mul_a), 32'(exp_a));
    check("mul_b", 32'(mul_b), 32'(exp_b));
    check("rsp_valid", 32'(rsp_valid), 32'(fifo.size() != 0));
    if (fifo.size() != 0) begin
      r = dlf_mul(fifo[0].a, fifo[0].b);
      check("rsp_id", 32'(rsp_id), fifo[0].id);
      check("rsp_result", 32'(rsp_result), 32'(r[24:5]));
      check("rsp_flags", 32'(rsp_flags), 32'(r[4:0]));
    end
    obs_ready = req_ready; obs_valid = rsp_valid; obs_id = rsp_id;
    obs_res = rsp_result; obs_flags = rsp_flags;
    exp_pop = (fifo.size() != 0) && rsp_ready;
    @(posedge clk);
    edge_n++;
    if (exp_pop) void'(fifo.pop_front());
    while (pend.size() != 0 && pend[0].due == edge_n) fifo.push_back(pend.pop_front());
    if (found) begin
      pend.push_back('{gi, req_a[gi*16 +: 16], req_b[gi*16 +: 16], edge_n + LAT + 1});
      exp_a = req_a[gi*16 +: 16];
      exp_b = req_b[gi*16 +: 16];
      m_ptr = (gi + 1) % NR;
    end else begin
      exp_a = '0; exp_b = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_result", 32'(rsp_result), 0);
    check("rst_rsp_flags", 32'(rsp_flags), 0);
    pend.delete(); fifo.delete();
    m_ptr = 0; exp_a = '0; exp_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    req_valid = '0; rsp_ready = 1'b1;
    repeat (n) step();
  endtask

  // Step with no new requests until a response shows; returns steps after the accept
  task automatic wait_rsp(output int unsigned lat, output bit got);
    lat = 0; got = 0;
    req_valid = '0;
    while (!got && lat < 10) begin
      step();
      if (obs_valid) got = 1; else lat++;
    end
  endtask

  initial begin
    int unsigned lat, acc;
    bit          got;
    n_tests = 0; n_fail = 0; m_ptr = 0; edge_n = 0;
    exp_a = '0; exp_b = '0;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Single request from requester 2: 1.0 * 2.0
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    set_req(2, 16'h3E00, 16'h4000);
    step();
    check("single_grant", 32'(obs_ready), 32'h4);
    wait_rsp(lat, got);
    check("single_seen", 32'(got), 1);
    check("single_lat", lat, LAT + 1);
    check("single_id", 32'(obs_id), 2);
    check("single_res", 32'(obs_res), 32'h40000);
    idle(3);

    // All requesters valid from a fresh pointer: strict 0,1,2,3 rotation
    do_reset();
    rsp_ready = 1'b1;
    for (int unsigned n = 0; n < 12; n++) begin
      req_valid = 4'hF;
      for (int unsigned i = 0; i < NR; i++) set_req(i, 16'($urandom), 16'($urandom));
      step();
      check("rr_grant", 32'(obs_ready), 32'(4'b0001 << (n % NR)));
    end
    idle(5);

    // Fairness: after a grant to 2, requesters 1 and 3 -> 3 first, then 1
    req_valid = 4'b0100;
    step();
    check("fair_g2", 32'(obs_ready), 32'h4);
    req_valid = 4'b1010;
    step();
    check("fair_g3", 32'(obs_ready), 32'h8);
    step();
    check("fair_g1", 32'(obs_ready), 32'h2);
    idle(6);

    // Backpressure: exactly DEPTH accepts, pop credit arrives a cycle later
    rsp_ready = 1'b0; req_valid = 4'hF; acc = 0;
    repeat (8) begin
      step();
      if (obs_ready != 0) acc++;
    end
    check("bp_accepts", acc, DEPTH);
    check("bp_stall", 32'(obs_ready), 0);
    rsp_ready = 1'b1;
    step();
    check("bp_pop_valid", 32'(obs_valid), 1);
    check("bp_pop_no_accept", 32'(obs_ready), 0);
    rsp_ready = 1'b0;
    step();
    check("bp_new_accept", 32'(obs_ready != 0), 1);
    step();
    check("bp_full_again", 32'(obs_ready), 0);
    idle(10);

    // Overflow flag pass-through
    req_valid = 4'b0010;
    set_req(1, 16'h7C00, 16'h7C00);
    step();
    wait_rsp(lat, got);
    check("flag_seen", 32'(got), 1);
    check("flag_id", 32'(obs_id), 1);
    check("flag_val", 32'(obs_flags), 32'h04);
    idle(3);

    // Random traffic with bursts of backpressure
    for (int unsigned n = 0; n < 400; n++) begin
      req_valid = 4'($urandom);
      for (int unsigned i = 0; i < NR; i++)
        if ($urandom_range(0, 15) == 0) set_req(i, 16'hFFFF, 16'($urandom));
        else set_req(i, 16'($urandom), 16'($urandom));
      rsp_ready = ((n / 40) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    idle(8);

    // Reset with responses queued and one product in flight
    rsp_ready = 1'b0; req_valid = 4'b0001;
    set_req(0, 16'h3E00, 16'h3E00);
    repeat (4) step();
    req_valid = '0;
    step();
    check("pre_rst_valid", 32'(obs_valid), 1);
    do_reset();
    idle(6);
    req_valid = 4'hF;
    step();
    check("post_rst_grant", 32'(obs_ready), 32'h1);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
